// File: rtl/rr_pkg.sv
// Shared constants and state encoding for the four-channel round-robin grant sequencer.
package rr_pkg;
    localparam int NUM_CH = 4;
    localparam int IDX_W  = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;
endpackage

// File: rtl/rr_pick4.sv
// Combinational rotate-priority picker: first requester after last_idx wins, last_idx itself ranks lowest.
module rr_pick4
    import rr_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  last_idx,
    output logic [IDX_W-1:0]  pick,
    output logic              any
);
    logic [IDX_W-1:0] cand;

    // Scan from lowest to highest priority so the highest-priority hit is written last.
    always_comb begin
        pick = '0;
        cand = '0;
        any  = |req;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            cand = last_idx + IDX_W'(i + 1);
            if (req[cand]) begin
                pick = cand;
            end
        end
    end
endmodule

// File: rtl/rr_grant_sequencer.sv
// Four-channel round-robin grant sequencer: one grant at a time, released on done, withdrawal or hold timeout.
module rr_grant_sequencer
    import rr_pkg::*;
#(
    parameter  int MAX_HOLD = 16,
    localparam int CNT_W    = $clog2(MAX_HOLD)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arb_en,
    input  logic [NUM_CH-1:0] req,
    input  logic              done,
    output logic [IDX_W-1:0]  grant_idx,
    output logic              grant_valid,
    output logic              timeout
);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] grant_idx_reg, grant_idx_next;
    logic             grant_valid_reg, grant_valid_next;
    logic             timeout_reg, timeout_next;
    logic [CNT_W-1:0] hold_cnt_reg, hold_cnt_next;
    logic [IDX_W-1:0] last_idx_reg, last_idx_next;

    logic [IDX_W-1:0] pick;
    logic             any;
    logic             at_limit;
    logic             still_req;

    rr_pick4 u_pick (
        .req      (req),
        .last_idx (last_idx_reg),
        .pick     (pick),
        .any      (any)
    );

    assign at_limit  = (hold_cnt_reg == HOLD_LAST);
    assign still_req = req[grant_idx_reg];

    always_comb begin
        state_next       = state_reg;
        grant_idx_next   = grant_idx_reg;
        grant_valid_next = grant_valid_reg;
        timeout_next     = 1'b0;
        hold_cnt_next    = hold_cnt_reg;
        last_idx_next    = last_idx_reg;
        case (state_reg)
            IDLE: begin
                grant_valid_next = 1'b0;
                if (arb_en && any) begin
                    grant_idx_next   = pick;
                    grant_valid_next = 1'b1;
                    hold_cnt_next    = '0;
                    state_next       = BUSY;
                end
            end
            BUSY: begin
                // done outranks withdrawal, which outranks the hold limit.
                if (done || !still_req || at_limit) begin
                    grant_valid_next = 1'b0;
                    last_idx_next    = grant_idx_reg;
                    timeout_next     = !done && still_req && at_limit;
                    state_next       = IDLE;
                end else begin
                    hold_cnt_next = hold_cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next       = IDLE;
                grant_valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            grant_idx_reg   <= '0;
            grant_valid_reg <= 1'b0;
            timeout_reg     <= 1'b0;
            hold_cnt_reg    <= '0;
            last_idx_reg    <= IDX_W'(NUM_CH - 1);
        end else begin
            state_reg       <= state_next;
            grant_idx_reg   <= grant_idx_next;
            grant_valid_reg <= grant_valid_next;
            timeout_reg     <= timeout_next;
            hold_cnt_reg    <= hold_cnt_next;
            last_idx_reg    <= last_idx_next;
        end
    end

    assign grant_idx   = grant_idx_reg;
    assign grant_valid = grant_valid_reg;
    assign timeout     = timeout_reg;
endmodule

// File: tb/tb_rr_grant_sequencer.sv
// Scenario bench for rr_grant_sequencer: expected grant indices are queued at stimulus time and checked on each new grant.
module tb_rr_grant_sequencer;
    logic       clk = 1'b0;
    logic       rst;
    logic       arb_en;
    logic [3:0] req;
    logic       done;
    logic [1:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    int         errors = 0;
    int         checks = 0;
    logic [1:0] sb_q[$];
    logic [1:0] exp_idx;
    logic       prev_valid = 1'b0;

    always #5 clk = ~clk;

    rr_grant_sequencer #(.MAX_HOLD(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .arb_en      (arb_en),
        .req         (req),
        .done        (done),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    // Scoreboard: every rising grant_valid consumes one expected index.
    always @(negedge clk) begin
        if (grant_valid === 1'b1 && prev_valid !== 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_grant: got unexpected grant idx=%0d, required no grant", grant_idx);
            end else begin
                exp_idx = sb_q.pop_front();
                if (grant_idx !== exp_idx) begin
                    errors++;
                    $display("FAIL sb_grant: got idx=%0d, required idx=%0d", grant_idx, exp_idx);
                end else begin
                    $display("grant idx=%0d at t=%0t", grant_idx, $time);
                end
            end
        end
        prev_valid = grant_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input string name);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (grant_valid === 1'b1) break;
        end
        checks++;
        if (grant_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s: grant_valid=%b after 10 cycles, required 1", name, grant_valid);
        end
    endtask

    task automatic release_done(input logic [3:0] nreq, input string name);
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = nreq;
        checks++;
        if (grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s: grant_valid=%b after done, required 0", name, grant_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; arb_en = 1'b0; req = 4'b0000; done = 1'b0;
        #2;
        checks += 3;
        if (grant_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", grant_valid); end
        if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b, required 0", timeout); end
        if (grant_idx !== 2'd0) begin errors++; $display("FAIL reset_idx: got %0d, required 0", grant_idx); end
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_rotation();
        req = 4'b1111; arb_en = 1'b1;
        for (int i = 0; i < 5; i++) sb_q.push_back(2'(i % 4));
        wait_grant("rot_first");
        for (int k = 0; k < 5; k++) begin
            tick();
            release_done((k == 4) ? 4'b0000 : 4'b1111, "rot_release");
            if (k < 4) begin
                tick();
                checks++;
                if (grant_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL rot_gap: grant_valid=%b two cycles after release, required 1", grant_valid);
                end
            end
        end
    endtask

    task automatic test_skip();
        req = 4'b0010; sb_q.push_back(2'd1);
        wait_grant("skip_first");
        release_done(4'b0010, "skip_rel1");
        sb_q.push_back(2'd1);
        wait_grant("skip_self");
        release_done(4'b1001, "skip_rel2");
        sb_q.push_back(2'd3);
        wait_grant("skip_over");
        release_done(4'b0000, "skip_rel3");
    endtask

    task automatic test_timeout();
        int cnt;
        int early;
        req = 4'b0100; sb_q.push_back(2'd2);
        wait_grant("to_grant");
        cnt = 1; early = 0;
        while (grant_valid === 1'b1 && cnt < 40) begin
            tick();
            if (grant_valid === 1'b1) begin
                cnt++;
                if (timeout !== 1'b0) early++;
            end
        end
        req = 4'b0000;
        checks += 3;
        if (cnt != 16) begin errors++; $display("FAIL to_len: grant held %0d cycles, required 16", cnt); end
        if (timeout !== 1'b1) begin errors++; $display("FAIL to_pulse: timeout=%b at release, required 1", timeout); end
        if (early != 0) begin errors++; $display("FAIL to_early: timeout seen %0d times while granted, required 0", early); end
        tick();
        checks += 2;
        if (timeout !== 1'b0) begin errors++; $display("FAIL to_width: timeout=%b one cycle later, required 0", timeout); end
        if (grant_valid !== 1'b0) begin errors++; $display("FAIL to_idle: grant_valid=%b, required 0", grant_valid); end
    endtask

    task automatic test_done_final();
        req = 4'b0100; sb_q.push_back(2'd2);
        wait_grant("df_grant");
        repeat (15) tick();
        checks++;
        if (grant_valid !== 1'b1) begin errors++; $display("FAIL df_still: grant_valid=%b at hold 15, required 1", grant_valid); end
        release_done(4'b0000, "df_release");
        checks++;
        if (timeout !== 1'b0) begin errors++; $display("FAIL df_no_timeout: timeout=%b, required 0", timeout); end
        tick();
        checks++;
        if (timeout !== 1'b0) begin errors++; $display("FAIL df_no_timeout2: timeout=%b, required 0", timeout); end
    endtask

    task automatic test_done_ignored();
        done = 1'b1; tick(); done = 1'b0;
        checks++;
        if (grant_valid !== 1'b0) begin errors++; $display("FAIL idle_done: grant_valid=%b, required 0", grant_valid); end
        req = 4'b0001; done = 1'b1; sb_q.push_back(2'd0);
        tick(); done = 1'b0;
        checks++;
        if (grant_valid !== 1'b1) begin errors++; $display("FAIL issue_done: grant_valid=%b, required 1", grant_valid); end
        tick();
        checks++;
        if (grant_valid !== 1'b1) begin errors++; $display("FAIL issue_done_hold: grant_valid=%b, required 1", grant_valid); end
        release_done(4'b0000, "issue_done_rel");
    endtask

    task automatic test_withdraw_enable();
        int seen;
        req = 4'b1111; sb_q.push_back(2'd1);
        wait_grant("wd_grant");
        tick();
        req = 4'b1101;
        tick();
        arb_en = 1'b0;
        checks += 2;
        if (grant_valid !== 1'b0) begin errors++; $display("FAIL wd_release: grant_valid=%b, required 0", grant_valid); end
        if (timeout !== 1'b0) begin errors++; $display("FAIL wd_timeout: timeout=%b, required 0", timeout); end
        seen = 0;
        repeat (5) begin tick(); if (grant_valid !== 1'b0) seen++; end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL en_gate: %0d granted cycles with arb_en=0, required 0", seen); end
        arb_en = 1'b1; sb_q.push_back(2'd2);
        wait_grant("en_grant");
        tick(); arb_en = 1'b0; tick(); tick();
        checks += 2;
        if (grant_valid !== 1'b1) begin errors++; $display("FAIL en_busy_hold: grant_valid=%b, required 1", grant_valid); end
        if (grant_idx !== 2'd2) begin errors++; $display("FAIL en_idx_stable: grant_idx=%0d, required 2", grant_idx); end
        release_done(4'b1101, "en_busy_done");
        tick(); tick();
        checks++;
        if (grant_valid !== 1'b0) begin errors++; $display("FAIL en_gate2: grant_valid=%b, required 0", grant_valid); end
        arb_en = 1'b1; sb_q.push_back(2'd3);
        wait_grant("en_regrant");
        release_done(4'b0000, "en_rel");
    endtask

    task automatic test_reset_mid_busy();
        req = 4'b0100; sb_q.push_back(2'd2);
        wait_grant("rm_grant");
        tick(); tick();
        #2 rst = 1'b1;
        #1;
        checks += 2;
        if (grant_valid !== 1'b0) begin errors++; $display("FAIL rm_valid: grant_valid=%b right after rst, required 0", grant_valid); end
        if (timeout !== 1'b0) begin errors++; $display("FAIL rm_timeout: timeout=%b right after rst, required 0", timeout); end
        tick();
        rst = 1'b0; req = 4'b1111; sb_q.push_back(2'd0);
        wait_grant("rm_regrant");
        release_done(4'b0000, "rm_rel");
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_skip();
        test_timeout();
        test_done_final();
        test_done_ignored();
        test_withdraw_enable();
        test_reset_mid_busy();
        tick(); tick();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d expected grants never seen, required 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
